result_uart_tx: RTL
===================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 8, giving clock cycles per UART bit; legal range 2..65535.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port digit_in, input, 4 bits: the recognised digit from the upstream classifier (handwriting digit_out).
REQ-005 The module SHALL have port result_valid, input, 1 bit: upstream result-valid level, which can stay high for many cycles.
REQ-006 The module SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-007 The module SHALL have port tx_busy, output, 1 bit: high while a message is being transmitted.
REQ-008 The module SHALL have port overrun, output, 1 bit: sticky flag set when a buffered result is overwritten.

Function
REQ-009 The module SHALL accept a result only on a rising edge of result_valid: sampled high in this cycle and low in the previous cycle (registered prev_valid); a held-high level SHALL produce exactly one capture.
REQ-010 On capture, the module SHALL latch digit_in in the same cycle.
REQ-011 Each capture SHALL produce one 3-byte message: the ASCII digit (0x30+digit_in for 0..9, else 0x3F '?'), then 0x0D, then 0x0A.
REQ-012 Each byte SHALL be framed as: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); every bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 Consecutive bytes of a message SHALL follow with no idle gap, so one message is exactly 30*CLKS_PER_BIT cycles.
REQ-014 The state machine SHALL have states IDLE, START, DATA, STOP, a bit counter of 0..7 and a byte index of 0..2.
REQ-015 STOP of byte index 2 SHALL go to IDLE, or directly to START if a next message is ready.
REQ-016 If a capture occurs in IDLE, tx SHALL go low (start bit) on the next cycle, and tx_busy SHALL go high on that same cycle.
REQ-017 tx_busy SHALL stay high until the last stop-bit cycle of the last queued message inclusive.
REQ-018 A capture while a message is in progress SHALL go into a one-entry pending buffer.
REQ-019 If the pending buffer is already full, the new digit SHALL overwrite it and overrun SHALL be set to 1.
REQ-020 overrun SHALL remain 1 until reset.
REQ-021 At the last stop-bit cycle of a message:
- if the pending buffer is full, the next cycle SHALL start the pending digit;
- if a capture occurs in that same cycle, it SHALL go into the freed pending slot without setting overrun;
- if the pending buffer is empty and a capture occurs in that cycle, the next cycle SHALL start the captured digit.
REQ-022 A transmission once started SHALL never be altered by later captures.

Reset
REQ-023 While rst=1, the outputs SHALL be: tx=1, tx_busy=0, overrun=0.
REQ-024 While rst=1, the internal state SHALL be: state=IDLE, counters=0, pending buffer empty, prev_valid=1.
REQ-025 Because prev_valid resets to 1, a result_valid held high through reset SHALL NOT trigger a message.
REQ-026 A reset asserted mid-message SHALL abandon the message; tx SHALL be 1 from the cycle after rst is sampled high.

Verification
REQ-027 Scenario (CLKS_PER_BIT=4): pulse result_valid for 1 cycle with digit_in=7 -> tx carries 0x37, 0x0D, 0x0A; tx_busy is high for exactly 120 cycles starting the cycle after capture; overrun=0.
REQ-028 Scenario: digit_in=12 -> first byte is 0x3F; hold result_valid high for 500 cycles -> exactly one message is sent.
REQ-029 Scenario: a second result (digit 2) arrives mid-message of digit 1 -> messages are sent back-to-back with no idle cycle between them; tx_busy stays high for 240 cycles; overrun=0.
REQ-030 Scenario: results 1, 2, 3 arrive during one message of digit 0 -> messages '0' then '3' are sent, '2' is lost, and overrun=1 until rst.
REQ-031 Scenario: capture arrives exactly in the last stop-bit cycle with pending empty -> the next message starts on the next cycle and overrun=0.
REQ-032 Scenario: rst asserted during a data bit -> next cycle tx=1 and tx_busy=0; result_valid held high through reset causes no message; a new rising edge then yields a normal message.

Source files
------------

// File: rtl/result_uart_tx.sv
// result_uart_tx: sends each captured classifier digit as "<ascii digit>\r\n" on an 8N1 UART line.
// Latency: start bit drives tx the cycle after the capturing edge; one message = 30*CLKS_PER_BIT cycles.
// Backpressure: none upstream; one pending slot, a newer result overwrites it and sets sticky overrun.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       result_valid,
    output logic       tx,
    output logic       tx_busy,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [3:0]  cur_digit_q, cur_digit_d;
    logic        pend_vld_q, pend_vld_d;
    logic [3:0]  pend_digit_q, pend_digit_d;
    logic        prev_valid_q, prev_valid_d;
    logic        tx_q, tx_d;
    logic        tx_busy_q, tx_busy_d;
    logic        overrun_q, overrun_d;

    logic        capture;
    logic        last_tick;
    logic        msg_end;
    logic [7:0]  byte_d;

    // Byte idx of the message for a given digit: ASCII digit ('?' if not 0..9), CR, LF.
    function automatic logic [7:0] msg_byte(input logic [3:0] digit, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = (digit <= 4'd9) ? (8'h30 + {4'h0, digit}) : 8'h3F;
            2'd1:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Next-state, pending-slot and registered-output computation.
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        cur_digit_d  = cur_digit_q;
        pend_vld_d   = pend_vld_q;
        pend_digit_d = pend_digit_q;
        overrun_d    = overrun_q;
        prev_valid_d = result_valid;

        // Edge-detect so a level held high for many cycles yields one capture.
        capture   = result_valid && !prev_valid_q;
        last_tick = (clk_cnt_q == CNT_MAX);
        msg_end   = (state_q == STOP) && (byte_idx_q == 2'd2) && last_tick;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d     = START;
                    cur_digit_d = digit_in;
                    clk_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    byte_idx_d  = '0;
                end
            end
            START: begin
                if (last_tick) begin
                    state_d   = DATA;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (last_tick) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (last_tick) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    if (byte_idx_q != 2'd2) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = START;
                    end else begin
                        // End of message: the pending digit has priority over a same-cycle capture.
                        byte_idx_d = '0;
                        if (pend_vld_q) begin
                            state_d     = START;
                            cur_digit_d = pend_digit_q;
                            pend_vld_d  = 1'b0;
                        end else if (capture) begin
                            state_d     = START;
                            cur_digit_d = digit_in;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture during a message parks in the pending slot, unless it is being
        // launched directly at the end of a message with the slot empty. Overwriting
        // a full slot loses a result, except at message end where the slot is freed.
        if (capture && (state_q != IDLE) && !(msg_end && !pend_vld_q)) begin
            pend_vld_d   = 1'b1;
            pend_digit_d = digit_in;
            if (pend_vld_q && !msg_end) begin
                overrun_d = 1'b1;
            end
        end

        // Outputs are registered from the next state so tx/tx_busy align with state_q.
        byte_d = msg_byte(cur_digit_d, byte_idx_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_d[bit_cnt_d];
            default: tx_d = 1'b1;
        endcase
        tx_busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            cur_digit_q  <= '0;
            pend_vld_q   <= 1'b0;
            pend_digit_q <= '0;
            prev_valid_q <= 1'b1;
            tx_q         <= 1'b1;
            tx_busy_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            cur_digit_q  <= cur_digit_d;
            pend_vld_q   <= pend_vld_d;
            pend_digit_q <= pend_digit_d;
            prev_valid_q <= prev_valid_d;
            tx_q         <= tx_d;
            tx_busy_q    <= tx_busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;
    assign overrun = overrun_q;

endmodule
